// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle of the memory access controller.
// The control unit drives the request fields (master); the controller answers (slave).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata_out;

  modport master (
    output req, wr, addr_in, wdata_in,
    input  ready, done, rdata_out
  );

  modport slave (
    input  req, wr, addr_in, wdata_in,
    output ready, done, rdata_out
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for the synchronous RAM: one request at a time, hides the
// registered-address read latency and optional wait states, reports completion with done.
module mem_access_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              clear_n,
  mem_access_ctrl_if.slave  cpu,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    DONE
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              read_q, read_d;
  logic              write_q, write_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (cpu.req) begin
          addr_d  = cpu.addr_in;
          wdata_d = cpu.wdata_in;
          cnt_d   = WAIT_INIT;
          state_d = cpu.wr ? WR_ISSUE : RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = ram_data_out;
          state_d = DONE;
        end
      end
      WR_ISSUE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they emerge from flops aligned with it.
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
    read_d  = (state_d == RD_ISSUE) || (state_d == RD_WAIT);
    write_d = (state_d == WR_ISSUE) && (cnt_d == 4'd0);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  assign cpu.ready     = ready_q;
  assign cpu.done      = done_q;
  assign cpu.rdata_out = rdata_q;
  assign ram_read      = read_q;
  assign ram_write     = write_q;
  assign ram_address   = addr_q;
  assign ram_data_in   = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (0, 3 and 2 wait states) each backed by a
// behavioural RAM with one-cycle registered read; completions are checked against a scoreboard.
module tb_mem_access_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int NDUT   = 3;
  localparam int DEPTH  = 512;

  typedef struct {
    int                k;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic clock = 1'b0;
  logic clear_n;
  logic clear2_n;
  logic mem_ready = 1'b0;

  logic [NDUT-1:0]   req_v, wr_v, ready_v, done_v, ram_read_v, ram_write_v;
  logic [ADDR_W-1:0] addr_v [NDUT];
  logic [ADDR_W-1:0] ram_address_v [NDUT];
  logic [DATA_W-1:0] wdata_v [NDUT];
  logic [DATA_W-1:0] rdata_v [NDUT];
  logic [DATA_W-1:0] ram_din_v [NDUT];
  logic [DATA_W-1:0] ram_dout_v [NDUT];

  logic [DATA_W-1:0] mem [NDUT][DEPTH];
  logic [DATA_W-1:0] shadow [NDUT][DEPTH];
  logic [DATA_W-1:0] last_rdata [NDUT];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  for (genvar k = 0; k < NDUT; k++) begin : g
    localparam int WS = (k == 1) ? 3 : ((k == 2) ? 2 : 0);

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    assign bus.req      = req_v[k];
    assign bus.wr       = wr_v[k];
    assign bus.addr_in  = addr_v[k];
    assign bus.wdata_in = wdata_v[k];
    assign ready_v[k]   = bus.ready;
    assign done_v[k]    = bus.done;
    assign rdata_v[k]   = bus.rdata_out;

    mem_access_ctrl #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .WAIT_STATES (WS)
    ) dut (
      .clock        (clock),
      .clear_n      ((k == 2) ? clear2_n : clear_n),
      .cpu          (bus.slave),
      .ram_read     (ram_read_v[k]),
      .ram_write    (ram_write_v[k]),
      .ram_address  (ram_address_v[k]),
      .ram_data_in  (ram_din_v[k]),
      .ram_data_out (ram_dout_v[k])
    );
  end

  function automatic logic [DATA_W-1:0] init_val(int k, int a);
    logic [DATA_W-1:0] v;
    v = 32'h5A00_0000 | (32'(k) << 16) | 32'(a);
    if (a == 'h47) v = 32'h0000_0094;
    return v;
  endfunction

  // RAM models: contents are loaded on the first edge, reads return data one edge after the address.
  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int k = 0; k < NDUT; k++)
        for (int a = 0; a < DEPTH; a++)
          mem[k][a] <= init_val(k, a);
      mem_ready <= 1'b1;
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        if (ram_write_v[k]) mem[k][ram_address_v[k]] <= ram_din_v[k];
        if (ram_read_v[k])  ram_dout_v[k] <= mem[k][ram_address_v[k]];
      end
    end
  end

  task automatic check_output(input string tag, input logic [DATA_W-1:0] got,
                              input logic [DATA_W-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every done pulse consumes one scoreboard entry; a pulse with nothing pending is an error.
  always @(negedge clock) begin
    for (int k = 0; k < NDUT; k++) begin
      if (done_v[k] === 1'b1) begin
        if (sb.size() == 0) begin
          check_output($sformatf("unexpected done dut%0d", k), 32'(done_v[k]), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output($sformatf("sb order dut%0d", k), 32'(k), 32'(e.k));
          check_output($sformatf("sb rdata dut%0d", k), rdata_v[k], e.rdata);
        end
      end
    end
  end

  task automatic apply_stimulus(input int k, input logic w, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, output int lat, output int rd_n,
                                output int wr_n, output int wr_pos);
    int t;
    lat = -1; rd_n = 0; wr_n = 0; wr_pos = -1; t = 0;
    @(negedge clock);
    while (ready_v[k] !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (ready_v[k] !== 1'b1) begin
      check_output("ready wait", 32'(ready_v[k]), 32'd1);
      return;
    end
    req_v[k] = 1'b1; wr_v[k] = w; addr_v[k] = a; wdata_v[k] = d;
    if (w) shadow[k][a] = d;
    else   last_rdata[k] = shadow[k][a];
    sb.push_back('{k, last_rdata[k]});
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (i == 0) begin
        req_v[k] = 1'b0; addr_v[k] = ~a; wdata_v[k] = ~d;
      end
      if (ram_write_v[k]) begin
        wr_n++;
        wr_pos = i;
      end
      if (ram_read_v[k]) rd_n++;
      if (done_v[k]) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, rd, wr, wp, rdy, dn, wcnt;
    clear_n = 1'b1; clear2_n = 1'b1;
    req_v = '0; wr_v = '0;
    for (int k = 0; k < NDUT; k++) begin
      addr_v[k] = '0; wdata_v[k] = '0; last_rdata[k] = '0;
      for (int a = 0; a < DEPTH; a++) shadow[k][a] = init_val(k, a);
    end
    #1 clear_n = 1'b0; clear2_n = 1'b0;
    #2;
    $display("[TB] reset values");
    for (int k = 0; k < NDUT; k++) begin
      check_output($sformatf("reset ready%0d", k), 32'(ready_v[k]), 32'd1);
      check_output($sformatf("reset done%0d", k), 32'(done_v[k]), 32'd0);
      check_output($sformatf("reset ram_read%0d", k), 32'(ram_read_v[k]), 32'd0);
      check_output($sformatf("reset ram_write%0d", k), 32'(ram_write_v[k]), 32'd0);
      check_output($sformatf("reset ram_address%0d", k), 32'(ram_address_v[k]), 32'd0);
      check_output($sformatf("reset ram_data_in%0d", k), ram_din_v[k], 32'd0);
      check_output($sformatf("reset rdata%0d", k), rdata_v[k], 32'd0);
    end
    repeat (2) @(negedge clock);
    clear_n = 1'b1; clear2_n = 1'b1;

    $display("[TB] load 0x47, no wait states");
    apply_stimulus(0, 1'b0, 9'h047, 32'h0, lat, rd, wr, wp);
    check_output("load latency", 32'(lat), 32'd2);
    check_output("load read cycles", 32'(rd), 32'd2);
    check_output("load write cycles", 32'(wr), 32'd0);
    @(negedge clock);
    check_output("load rdata held", rdata_v[0], 32'h0000_0094);
    check_output("load address held", 32'(ram_address_v[0]), 32'h047);

    $display("[TB] store then load 0x8E");
    apply_stimulus(0, 1'b1, 9'h08E, 32'hDEAD_BEEF, lat, rd, wr, wp);
    check_output("store latency", 32'(lat), 32'd1);
    check_output("store write cycles", 32'(wr), 32'd1);
    check_output("store write position", 32'(wp), 32'd0);
    check_output("store read cycles", 32'(rd), 32'd0);
    @(negedge clock);
    check_output("store keeps rdata", rdata_v[0], 32'h0000_0094);
    apply_stimulus(0, 1'b0, 9'h08E, 32'h0, lat, rd, wr, wp);
    check_output("reload latency", 32'(lat), 32'd2);

    $display("[TB] reset during read");
    @(negedge clock);
    @(negedge clock);
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 9'h047;
    @(posedge clock);
    #2;
    req_v[0] = 1'b0;
    clear_n = 1'b0;
    #1;
    check_output("abort ready", 32'(ready_v[0]), 32'd1);
    check_output("abort ram_read", 32'(ram_read_v[0]), 32'd0);
    check_output("abort rdata", rdata_v[0], 32'd0);
    check_output("abort address", 32'(ram_address_v[0]), 32'd0);
    check_output("abort done", 32'(done_v[0]), 32'd0);
    repeat (3) @(negedge clock);
    clear_n = 1'b1;
    last_rdata[0] = '0;
    repeat (3) @(negedge clock);
    check_output("abort ready after release", 32'(ready_v[0]), 32'd1);

    $display("[TB] three wait states");
    apply_stimulus(1, 1'b0, 9'h047, 32'h0, lat, rd, wr, wp);
    check_output("ws3 load latency", 32'(lat), 32'd5);
    check_output("ws3 read cycles", 32'(rd), 32'd5);
    apply_stimulus(1, 1'b1, 9'h08E, 32'hCAFE_F00D, lat, rd, wr, wp);
    check_output("ws3 store latency", 32'(lat), 32'd4);
    check_output("ws3 write cycles", 32'(wr), 32'd1);
    check_output("ws3 write position", 32'(wp), 32'd3);
    apply_stimulus(1, 1'b0, 9'h08E, 32'h0, lat, rd, wr, wp);
    check_output("ws3 reload latency", 32'(lat), 32'd5);

    $display("[TB] requests outside idle are ignored");
    @(negedge clock);
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 9'h047;
    last_rdata[0] = shadow[0][9'h047];
    sb.push_back('{0, last_rdata[0]});
    @(negedge clock);
    req_v[0] = 1'b0;
    @(negedge clock);
    req_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 9'h100; wdata_v[0] = 32'h5555_5555;
    @(negedge clock);
    check_output("ignored done", 32'(done_v[0]), 32'd1);
    check_output("ignored address in done", 32'(ram_address_v[0]), 32'h047);
    check_output("ignored write in done", 32'(ram_write_v[0]), 32'd0);
    @(negedge clock);
    req_v[0] = 1'b0;
    check_output("ignored ready", 32'(ready_v[0]), 32'd1);
    check_output("ignored address in idle", 32'(ram_address_v[0]), 32'h047);
    check_output("ignored ram unchanged", mem[0][9'h100], shadow[0][9'h100]);

    $display("[TB] back-to-back loads with req held");
    @(negedge clock);
    req_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = 9'h047;
    for (int n = 0; n < 3; n++) sb.push_back('{0, shadow[0][9'h047]});
    rdy = 0; dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (ready_v[0]) rdy++;
      if (done_v[0]) dn++;
      if (i == 8) req_v[0] = 1'b0;
    end
    check_output("b2b ready cycles", 32'(rdy), 32'd3);
    check_output("b2b done pulses", 32'(dn), 32'd3);

    $display("[TB] reset during delayed store");
    @(negedge clock);
    req_v[2] = 1'b1; wr_v[2] = 1'b1; addr_v[2] = 9'h030; wdata_v[2] = 32'h1234_5678;
    @(negedge clock);
    req_v[2] = 1'b0;
    check_output("abort2 early write", 32'(ram_write_v[2]), 32'd0);
    clear2_n = 1'b0;
    #1;
    check_output("abort2 ready", 32'(ready_v[2]), 32'd1);
    check_output("abort2 ram_data_in", ram_din_v[2], 32'd0);
    wcnt = 0; dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (ram_write_v[2]) wcnt++;
      if (done_v[2]) dn++;
    end
    check_output("abort2 write count", 32'(wcnt), 32'd0);
    check_output("abort2 done count", 32'(dn), 32'd0);
    clear2_n = 1'b1;
    @(negedge clock);
    check_output("abort2 ready after release", 32'(ready_v[2]), 32'd1);
    check_output("abort2 ram unchanged", mem[2][9'h030], shadow[2][9'h030]);
    apply_stimulus(2, 1'b0, 9'h030, 32'h0, lat, rd, wr, wp);
    check_output("ws2 load latency", 32'(lat), 32'd4);

    repeat (2) @(negedge clock);
    check_output("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
